systolic_mesh_ctrl: RTL and testbench
=====================================

Name: systolic_mesh_ctrl

Overview:
- Next-generation systolic mesh: rectangular ROWS x COLS grid of ProcessingElement instances, with flat-packed boundary buses and an explicit run-control FSM.
- Adds behaviour the square mesh lacks:
  - start/clear handshake;
  - gating of injected valid and last-element while idle;
  - same-cycle completion detection;
  - run cycle counter;
  - watchdog timeout.
- Sits between the input queues and the result-drain logic.

Parameters:
- ROWS, 2, number of PE rows (>=1)
- COLS, 2, number of PE columns (>=1)
- DATA_WIDTH, 32, data/weight width per PE
- CNT_WIDTH, 16, width of cycle counter
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN/WAIT_PT; 0 disables the watchdog

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  begin a run; accepted only in IDLE or DONE
- clear_i  in  1  return to IDLE from DONE or TIMEOUT
- north_i  in  COLS*DATA_WIDTH  top-boundary data; column c at [c*DATA_WIDTH +: DATA_WIDTH]
- west_i  in  ROWS*DATA_WIDTH  left-boundary weights; row r at [r*DATA_WIDTH +: DATA_WIDTH]
- inputs_valid_i  in  1  valid for PE[0][0]
- last_element_i  in  1  pulse: final element released from queue; drives bottom-row PE[ROWS-1][0]
- select_accumulator_i  in  ROWS*COLS  per-PE accumulator select; PE[r][c] at bit r*COLS+c
- south_o  out  COLS*DATA_WIDTH  bottom-row data outputs
- east_o  out  ROWS*DATA_WIDTH  right-column weight outputs
- passthrough_valid_o  out  ROWS*COLS  per-PE passthrough valid, same indexing
- accumulator_valid_o  out  ROWS*COLS  per-PE accumulator valid
- last_element_east_o  out  1  last-element from PE[ROWS-1][COLS-1]
- busy_o  out  1  FSM in RUN or WAIT_PT
- done_o  out  1  level, high in DONE
- timeout_o  out  1  level, high in TIMEOUT
- cycles_o  out  CNT_WIDTH  cycles spent in RUN+WAIT_PT for the current/last run

Behaviour:
- Reset (async, rstn_i low):
  - FSM=IDLE; busy_o, done_o, timeout_o = 0; cycles_o = 0.
  - PEs reset via the same rstn_i.
- Mesh wiring:
  - North data flows down columns; west weights flow right along rows.
  - last_element chains only along the bottom row; the other rows' PE last_element inputs are tied 0.
- Valid wiring:
  - PE[0][0] gets the gated valid.
  - Row 0 takes its west neighbour's passthrough_valid; column 0 takes its north neighbour's.
  - Interior PEs take north AND west passthrough_valid.
- Gating: PE[0][0] valid = inputs_valid_i & busy_o; bottom-row chain input = last_element_i & busy_o. Inputs arriving in IDLE/DONE/TIMEOUT are dropped.
- FSM states IDLE, RUN, WAIT_PT, DONE, TIMEOUT (encoding in package):
  - IDLE: start_i -> RUN; cycles_o <= 0.
  - RUN: cycles_o increments each cycle, saturating at all-ones.
    - last_element_east_o=1 and passthrough_valid[ROWS-1][COLS-1]=1 in the same cycle -> DONE directly.
    - last_element_east_o=1 alone -> WAIT_PT.
  - WAIT_PT: cycles_o increments; passthrough_valid[ROWS-1][COLS-1]=1 -> DONE.
  - Watchdog: in RUN or WAIT_PT, if TIMEOUT_CYCLES != 0 and cycles_o reaches TIMEOUT_CYCLES-1 without completing -> TIMEOUT. Completion in that same cycle wins.
  - DONE: cycles_o frozen; clear_i -> IDLE; start_i -> RUN with counter reset. start_i has priority over clear_i.
  - TIMEOUT: cycles_o frozen; clear_i -> IDLE. start_i is ignored until cleared.
- Busy guard: start_i in RUN/WAIT_PT is ignored; clear_i in RUN/WAIT_PT is ignored.
- Pulse width: a second last_element_east_o pulse while in WAIT_PT is ignored. Outputs are registered, so done_o asserts the cycle after the completing condition.
- Reset mid-run: immediate IDLE; no done/timeout is reported.
- Datapath outputs pass straight from PEs with no added latency.

Decomposition:
- Package systolic_pkg: mesh_state_e enum (IDLE, RUN, WAIT_PT, DONE, TIMEOUT).
- Sub-module mesh_run_ctrl: FSM, counter, watchdog. Its inputs are start/clear, end-of-row last-element and corner passthrough-valid; its outputs are busy/done/timeout/cycles.
- The top level holds the generate loops over ProcessingElement and the gating.

Test Plan:
- ROWS=2, COLS=3, start_i then 4 valid beats and last_element_i on beat 4 -> busy_o high until done_o rises; cycles_o equals the cycle count from start to the corner passthrough pulse; done_o holds until clear_i.
- inputs_valid_i=1 and last_element_i=1 while IDLE -> all passthrough_valid_o stay 0x00, done_o stays 0, FSM stays IDLE.
- Force last_element_east_o and corner passthrough_valid in the same cycle (ROWS=COLS=1, single beat with last) -> done_o asserts next cycle with no WAIT_PT dwell.
- TIMEOUT_CYCLES=16, start_i, no last_element_i -> timeout_o=1 after exactly 16 busy cycles, cycles_o=15; clear_i -> IDLE with all status 0.
- In DONE, start_i and clear_i together -> RUN entered, cycles_o=0, done_o drops next cycle.
- Assert rstn_i=0 mid-WAIT_PT -> busy_o, done_o, timeout_o, cycles_o all 0 immediately; a start after reset completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the systolic mesh: run-control FSM state encoding and
// the PE flat-bus index helper used by the top level.
package systolic_pkg;

  typedef enum logic [2:0] {
    MS_IDLE    = 3'd0,
    MS_RUN     = 3'd1,
    MS_WAIT_PT = 3'd2,
    MS_DONE    = 3'd3,
    MS_TIMEOUT = 3'd4
  } mesh_state_e;

  // Bit position of PE[r][c] in the per-PE flat status buses.
  function automatic int unsigned pe_idx(input int unsigned r,
                                         input int unsigned c,
                                         input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/mesh_run_ctrl.sv
// Run-control FSM for the mesh: start/clear handshake, completion detect,
// saturating run-cycle counter and watchdog.
//   clk_i, rstn_i        clock, async active-low reset
//   start_i, clear_i     run request / return to idle
//   last_east_i          last-element leaving the bottom-right PE
//   corner_valid_i       passthrough valid of the bottom-right PE
//   busy_o               in RUN or WAIT_PT
//   done_o, timeout_o    terminal status levels
//   cycles_o             cycles spent busy in the current / last run
module mesh_run_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic                 last_east_i,
  input  logic                 corner_valid_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] cycles_o
);

  mesh_state_e          state_q;
  logic [CNT_WIDTH-1:0] cycles_inc;
  logic                 wd_hit;

  assign cycles_inc = (&cycles_o) ? cycles_o : cycles_o + CNT_WIDTH'(1);
  assign wd_hit     = (TIMEOUT_CYCLES != 0) &&
                      (cycles_o == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Completion beats the watchdog; on timeout the counter is left frozen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= MS_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      cycles_o  <= '0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (start_i) begin
            state_q  <= MS_RUN;
            busy_o   <= 1'b1;
            cycles_o <= '0;
          end
        end
        MS_RUN: begin
          if (last_east_i && corner_valid_i) begin
            state_q  <= MS_DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            cycles_o <= cycles_inc;
          end else if (wd_hit) begin
            state_q   <= MS_TIMEOUT;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end else if (last_east_i) begin
            state_q  <= MS_WAIT_PT;
            cycles_o <= cycles_inc;
          end else begin
            cycles_o <= cycles_inc;
          end
        end
        MS_WAIT_PT: begin
          if (corner_valid_i) begin
            state_q  <= MS_DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            cycles_o <= cycles_inc;
          end else if (wd_hit) begin
            state_q   <= MS_TIMEOUT;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            cycles_o <= cycles_inc;
          end
        end
        MS_DONE: begin
          if (start_i) begin
            state_q  <= MS_RUN;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            cycles_o <= '0;
          end else if (clear_i) begin
            state_q  <= MS_IDLE;
            done_o   <= 1'b0;
            cycles_o <= '0;
          end
        end
        MS_TIMEOUT: begin
          if (clear_i) begin
            state_q   <= MS_IDLE;
            timeout_o <= 1'b0;
            cycles_o  <= '0;
          end
        end
        default: begin
          state_q   <= MS_IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
          timeout_o <= 1'b0;
          cycles_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/processing_element.sv
// One mesh cell. Registers north data downward and west weight rightward
// when valid_i is set, and forwards valid / last-element one cycle later.
//   clk_i, rstn_i          clock, async active-low reset
//   north_i, west_i        incoming data / weight
//   valid_i                this cell's input is valid
//   last_element_i         last-element chain input
//   select_accumulator_i   this cell reports accumulator-valid
//   south_o, east_o        registered data / weight toward neighbours
//   passthrough_valid_o    registered valid_i
//   accumulator_valid_o    registered valid_i & select_accumulator_i
//   last_element_o         registered last_element_i
module processing_element #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] north_i,
  input  logic [DATA_WIDTH-1:0] west_i,
  input  logic                  valid_i,
  input  logic                  last_element_i,
  input  logic                  select_accumulator_i,
  output logic [DATA_WIDTH-1:0] south_o,
  output logic [DATA_WIDTH-1:0] east_o,
  output logic                  passthrough_valid_o,
  output logic                  accumulator_valid_o,
  output logic                  last_element_o
);

  // Data holds between valid beats; control bits are one-cycle delayed copies.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      south_o             <= '0;
      east_o              <= '0;
      passthrough_valid_o <= 1'b0;
      accumulator_valid_o <= 1'b0;
      last_element_o      <= 1'b0;
    end else begin
      passthrough_valid_o <= valid_i;
      accumulator_valid_o <= valid_i & select_accumulator_i;
      last_element_o      <= last_element_i;
      if (valid_i) begin
        south_o <= north_i;
        east_o  <= west_i;
      end
    end
  end

endmodule

// File: rtl/systolic_mesh_ctrl.sv
// ROWS x COLS systolic mesh with run control. Boundary injections are gated
// by busy so nothing enters the array outside a run.
//   clk_i, rstn_i           clock, async active-low reset
//   start_i, clear_i        run control
//   north_i, west_i         boundary data (per column) / weights (per row)
//   inputs_valid_i          valid for PE[0][0]
//   last_element_i          last-element into bottom row PE[ROWS-1][0]
//   select_accumulator_i    per-PE accumulator select, bit r*COLS+c
//   south_o, east_o         bottom-row data / right-column weights
//   passthrough_valid_o     per-PE passthrough valid
//   accumulator_valid_o     per-PE accumulator valid
//   last_element_east_o     last-element out of PE[ROWS-1][COLS-1]
//   busy_o, done_o, timeout_o, cycles_o   run status
module systolic_mesh_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS           = 2,
  parameter int unsigned COLS           = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  input  logic                       clear_i,
  input  logic [COLS*DATA_WIDTH-1:0] north_i,
  input  logic [ROWS*DATA_WIDTH-1:0] west_i,
  input  logic                       inputs_valid_i,
  input  logic                       last_element_i,
  input  logic [ROWS*COLS-1:0]       select_accumulator_i,
  output logic [COLS*DATA_WIDTH-1:0] south_o,
  output logic [ROWS*DATA_WIDTH-1:0] east_o,
  output logic [ROWS*COLS-1:0]       passthrough_valid_o,
  output logic [ROWS*COLS-1:0]       accumulator_valid_o,
  output logic                       last_element_east_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic [CNT_WIDTH-1:0]       cycles_o
);

  logic                  busy;
  logic                  valid_gated;
  logic                  last_gated;
  logic [DATA_WIDTH-1:0] south_arr [ROWS][COLS];
  logic [DATA_WIDTH-1:0] east_arr  [ROWS][COLS];
  logic                  pv_arr    [ROWS][COLS];
  logic                  av_arr    [ROWS][COLS];
  logic                  last_arr  [ROWS][COLS];

  assign valid_gated = inputs_valid_i & busy;
  assign last_gated  = last_element_i & busy;
  assign busy_o      = busy;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic                  pe_valid;
      logic                  pe_last;
      logic [DATA_WIDTH-1:0] pe_north;
      logic [DATA_WIDTH-1:0] pe_west;

      // Interior cells fire only when both upstream neighbours agree.
      if (r == 0 && c == 0) begin : g_v00
        assign pe_valid = valid_gated;
      end else if (r == 0) begin : g_vtop
        assign pe_valid = pv_arr[0][c-1];
      end else if (c == 0) begin : g_vleft
        assign pe_valid = pv_arr[r-1][0];
      end else begin : g_vint
        assign pe_valid = pv_arr[r-1][c] & pv_arr[r][c-1];
      end

      // last-element travels only along the bottom row.
      if (r == ROWS - 1) begin : g_lbot
        if (c == 0) begin : g_lfirst
          assign pe_last = last_gated;
        end else begin : g_lchain
          assign pe_last = last_arr[r][c-1];
        end
      end else begin : g_lnone
        assign pe_last = 1'b0;
      end

      if (r == 0) begin : g_ntop
        assign pe_north = north_i[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_nin
        assign pe_north = south_arr[r-1][c];
      end

      if (c == 0) begin : g_wleft
        assign pe_west = west_i[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_win
        assign pe_west = east_arr[r][c-1];
      end

      processing_element #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_pe (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .north_i             (pe_north),
        .west_i              (pe_west),
        .valid_i             (pe_valid),
        .last_element_i      (pe_last),
        .select_accumulator_i(select_accumulator_i[pe_idx(r, c, COLS)]),
        .south_o             (south_arr[r][c]),
        .east_o              (east_arr[r][c]),
        .passthrough_valid_o (pv_arr[r][c]),
        .accumulator_valid_o (av_arr[r][c]),
        .last_element_o      (last_arr[r][c])
      );

      assign passthrough_valid_o[pe_idx(r, c, COLS)] = pv_arr[r][c];
      assign accumulator_valid_o[pe_idx(r, c, COLS)] = av_arr[r][c];

      if (r == ROWS - 1) begin : g_sout
        assign south_o[c*DATA_WIDTH +: DATA_WIDTH] = south_arr[r][c];
      end
      if (c == COLS - 1) begin : g_eout
        assign east_o[r*DATA_WIDTH +: DATA_WIDTH] = east_arr[r][c];
      end
    end
  end

  assign last_element_east_o = last_arr[ROWS-1][COLS-1];

  mesh_run_ctrl #(
    .CNT_WIDTH     (CNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ctrl (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .last_east_i   (last_arr[ROWS-1][COLS-1]),
    .corner_valid_i(pv_arr[ROWS-1][COLS-1]),
    .busy_o        (busy),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .cycles_o      (cycles_o)
  );

endmodule

// File: tb/tb_systolic_mesh_ctrl.sv
// Directed bench: a 2x3 mesh with a 16-cycle watchdog driven from a
// per-cycle vector table, plus a 1x1 mesh for same-cycle completion and
// hand-written sequences for timeout, start/clear collision and mid-run reset.
module tb_systolic_mesh_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic clk;
  logic rstn;

  // 2x3 instance
  logic          a_start, a_clear, a_valid, a_last;
  logic [3*DW-1:0] a_north, a_south;
  logic [2*DW-1:0] a_west, a_east;
  logic [5:0]    a_sel, a_pv, a_av;
  logic          a_le, a_busy, a_done, a_tmo;
  logic [CW-1:0] a_cyc;

  // 1x1 instance
  logic          b_start, b_clear, b_valid, b_last;
  logic [DW-1:0] b_north, b_south, b_west, b_east;
  logic [0:0]    b_sel, b_pv, b_av;
  logic          b_le, b_busy, b_done, b_tmo;
  logic [CW-1:0] b_cyc;

  int checks = 0;
  int errors = 0;

  systolic_mesh_ctrl #(
    .ROWS(2), .COLS(3), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(16)
  ) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(a_start), .clear_i(a_clear),
    .north_i(a_north), .west_i(a_west), .inputs_valid_i(a_valid),
    .last_element_i(a_last), .select_accumulator_i(a_sel),
    .south_o(a_south), .east_o(a_east), .passthrough_valid_o(a_pv),
    .accumulator_valid_o(a_av), .last_element_east_o(a_le),
    .busy_o(a_busy), .done_o(a_done), .timeout_o(a_tmo), .cycles_o(a_cyc)
  );

  systolic_mesh_ctrl #(
    .ROWS(1), .COLS(1), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(4096)
  ) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(b_start), .clear_i(b_clear),
    .north_i(b_north), .west_i(b_west), .inputs_valid_i(b_valid),
    .last_element_i(b_last), .select_accumulator_i(b_sel),
    .south_o(b_south), .east_o(b_east), .passthrough_valid_o(b_pv),
    .accumulator_valid_o(b_av), .last_element_east_o(b_le),
    .busy_o(b_busy), .done_o(b_done), .timeout_o(b_tmo), .cycles_o(b_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start, clear, valid, last;
    logic        busy, done, tmo, le;
    logic [15:0] cyc;
    logic [5:0]  pv;
    logic [23:0] south;
    logic [15:0] east;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int idx, input logic busy,
                       input logic done, input logic tmo, input logic [15:0] cyc);
    chk({tag, "_busy"}, idx, 32'(a_busy), 32'(busy));
    chk({tag, "_done"}, idx, 32'(a_done), 32'(done));
    chk({tag, "_tmo"},  idx, 32'(a_tmo),  32'(tmo));
    chk({tag, "_cyc"},  idx, 32'(a_cyc),  32'(cyc));
  endtask

  task automatic chk_b(input string tag, input int idx, input logic busy,
                       input logic done, input logic [15:0] cyc);
    chk({tag, "_busy"}, idx, 32'(b_busy), 32'(busy));
    chk({tag, "_done"}, idx, 32'(b_done), 32'(done));
    chk({tag, "_tmo"},  idx, 32'(b_tmo),  32'(1'b0));
    chk({tag, "_cyc"},  idx, 32'(b_cyc),  32'(cyc));
  endtask

  initial begin
    // start clear valid last | busy done tmo le | cyc | pv | south | east
    tbl[0]  = '{1,0,0,0, 1,0,0,0, 16'd0,  6'h00, 24'h000000, 16'h0000};
    tbl[1]  = '{0,0,1,0, 1,0,0,0, 16'd1,  6'h01, 24'h000000, 16'h0000};
    tbl[2]  = '{0,0,0,0, 1,0,0,0, 16'd2,  6'h0A, 24'h000011, 16'h0000};
    tbl[3]  = '{0,0,1,0, 1,0,0,0, 16'd3,  6'h15, 24'h002211, 16'h00AA};
    tbl[4]  = '{0,0,0,0, 1,0,0,0, 16'd4,  6'h2A, 24'h332211, 16'hBBAA};
    tbl[5]  = '{0,0,1,0, 1,0,0,0, 16'd5,  6'h15, 24'h332211, 16'hBBAA};
    tbl[6]  = '{0,0,0,0, 1,0,0,0, 16'd6,  6'h2A, 24'h332211, 16'hBBAA};
    tbl[7]  = '{0,0,1,1, 1,0,0,0, 16'd7,  6'h15, 24'h332211, 16'hBBAA};
    tbl[8]  = '{0,0,0,0, 1,0,0,0, 16'd8,  6'h2A, 24'h332211, 16'hBBAA};
    tbl[9]  = '{0,0,0,0, 1,0,0,1, 16'd9,  6'h14, 24'h332211, 16'hBBAA};
    tbl[10] = '{0,0,0,0, 1,0,0,0, 16'd10, 6'h20, 24'h332211, 16'hBBAA};
    tbl[11] = '{0,0,0,0, 0,1,0,0, 16'd11, 6'h00, 24'h332211, 16'hBBAA};
    tbl[12] = '{0,0,1,1, 0,1,0,0, 16'd11, 6'h00, 24'h332211, 16'hBBAA};
    tbl[13] = '{0,1,0,0, 0,0,0,0, 16'd0,  6'h00, 24'h332211, 16'hBBAA};
    tbl[14] = '{0,0,1,1, 0,0,0,0, 16'd0,  6'h00, 24'h332211, 16'hBBAA};
    tbl[15] = '{0,0,0,0, 0,0,0,0, 16'd0,  6'h00, 24'h332211, 16'hBBAA};
    tbl[16] = '{0,0,0,0, 0,0,0,0, 16'd0,  6'h00, 24'h332211, 16'hBBAA};
    tbl[17] = '{0,0,0,0, 0,0,0,0, 16'd0,  6'h00, 24'h332211, 16'hBBAA};

    rstn = 1'b0;
    a_start = 0; a_clear = 0; a_valid = 0; a_last = 0;
    a_north = {8'h33, 8'h22, 8'h11};
    a_west  = {8'hBB, 8'hAA};
    a_sel   = 6'h21;
    b_start = 0; b_clear = 0; b_valid = 0; b_last = 0;
    b_north = 8'h5A; b_west = 8'hC3; b_sel = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk_a("rst_in", 0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk_a("rst_out", 0, 0, 0, 0, 16'd0);
    chk("rst_pv", 0, 32'(a_pv), 32'h0);
    chk_b("rst_b", 0, 0, 0, 16'd0);

    // Main 2x3 run with gapped beats, then drop checks in DONE / IDLE.
    for (int i = 0; i < NVEC; i++) begin
      a_start = tbl[i].start; a_clear = tbl[i].clear;
      a_valid = tbl[i].valid; a_last  = tbl[i].last;
      step();
      chk_a("tbl", i, tbl[i].busy, tbl[i].done, tbl[i].tmo, tbl[i].cyc);
      chk("tbl_le",    i, 32'(a_le),    32'(tbl[i].le));
      chk("tbl_pv",    i, 32'(a_pv),    32'(tbl[i].pv));
      chk("tbl_av",    i, 32'(a_av),    32'(tbl[i].pv & 6'h21));
      chk("tbl_south", i, 32'(a_south), 32'(tbl[i].south));
      chk("tbl_east",  i, 32'(a_east),  32'(tbl[i].east));
    end
    a_start = 0; a_clear = 0; a_valid = 0; a_last = 0;

    // Watchdog: 16 busy cycles, counter frozen at 15, start ignored, clear.
    a_start = 1; step(); a_start = 0;
    chk_a("to_start", 0, 1, 0, 0, 16'd0);
    repeat (15) step();
    chk_a("to_edge15", 0, 1, 0, 0, 16'd15);
    step();
    chk_a("to_fire", 0, 0, 0, 1, 16'd15);
    a_start = 1; step(); a_start = 0;
    chk_a("to_start_ign", 0, 0, 0, 1, 16'd15);
    a_clear = 1; step(); a_clear = 0;
    chk_a("to_clear", 0, 0, 0, 0, 16'd0);

    // 1x1: last and corner valid coincide -> DONE with no WAIT_PT dwell.
    b_start = 1; step(); b_start = 0;
    chk_b("b_start", 0, 1, 0, 16'd0);
    b_valid = 1; b_last = 1; step(); b_valid = 0; b_last = 0;
    chk_b("b_beat", 0, 1, 0, 16'd1);
    chk("b_le", 0, 32'(b_le), 32'h1);
    chk("b_pv", 0, 32'(b_pv), 32'h1);
    chk("b_south", 0, 32'(b_south), 32'h5A);
    chk("b_east", 0, 32'(b_east), 32'hC3);
    step();
    chk_b("b_done", 0, 0, 1, 16'd2);
    // start and clear together in DONE: start wins.
    b_start = 1; b_clear = 1; step(); b_start = 0; b_clear = 0;
    chk_b("b_restart", 0, 1, 0, 16'd0);
    b_valid = 1; b_last = 1; step(); b_valid = 0; b_last = 0;
    chk_b("b_beat", 1, 1, 0, 16'd1);
    step();
    chk_b("b_done", 1, 0, 1, 16'd2);
    b_clear = 1; step(); b_clear = 0;
    chk_b("b_clear", 0, 0, 0, 16'd0);

    // Reset while the 2x3 mesh sits in WAIT_PT.
    a_start = 1; step(); a_start = 0;
    a_valid = 1; a_last = 1; step(); a_valid = 0; a_last = 0;
    step(); step();
    chk("wp_le", 0, 32'(a_le), 32'h1);
    step();
    chk_a("wp_dwell", 0, 1, 0, 0, 16'd4);
    chk("wp_corner", 0, 32'(a_pv), 32'h20);
    #2 rstn = 1'b0;
    #1;
    chk_a("wp_rst", 0, 0, 0, 0, 16'd0);
    chk("wp_rst_pv", 0, 32'(a_pv), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    a_start = 1; step(); a_start = 0;
    chk_a("post_start", 0, 1, 0, 0, 16'd0);
    a_valid = 1; a_last = 1; step(); a_valid = 0; a_last = 0;
    step(); step(); step();
    chk_a("post_wait", 0, 1, 0, 0, 16'd4);
    step();
    chk_a("post_done", 0, 0, 1, 0, 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
